// File: rtl/indicator_arbiter_if.sv
// Producer/indicator bundle for indicator_arbiter.
// master = producers + indicator side, slave = arbiter.
interface indicator_arbiter_if #(
    parameter int N_SRC = 2
) ();
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]   req_valid;
    logic [8*N_SRC-1:0] req_data;
    logic [N_SRC-1:0]   req_ack;
    logic [7:0]         out_data;
    logic               out_ready;
    logic [GW-1:0]      grant_id;
    logic               busy;

    modport master (
        output req_valid, req_data,
        input  req_ack, out_data, out_ready, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ack, out_data, out_ready, grant_id, busy
    );
endinterface

// File: rtl/indicator_arbiter.sv
// Round-robin arbiter sharing the LED indicator byte/strobe input.
// Optional ARB_DEDUP_EN: repeated bytes are acked but not strobed.
module indicator_arbiter #(
    parameter int N_SRC = 2,
    parameter int GAP   = 4
) (
    input logic clk,
    input logic reset,
    indicator_arbiter_if.slave bus
);
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic [GW-1:0]    gid_q, gid_d;
    logic             busy_q, busy_d;
`ifdef ARB_DEDUP_EN
    logic             seen_q, seen_d;
`endif

    logic             hit;
    logic [GW-1:0]    win;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] cand_oh;
    logic [7:0]       win_byte;
    int               idx;

    // Pick the first valid source after the last granted one.
    always_comb begin
        hit      = 1'b0;
        win      = '0;
        win_oh   = '0;
        cand_oh  = '0;
        idx      = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx     = (int'(last_q) + k) % N_SRC;
            cand_oh = {{(N_SRC-1){1'b0}}, 1'b1} << idx;
            if (!hit && |(bus.req_valid & cand_oh)) begin
                hit    = 1'b1;
                win    = GW'(idx);
                win_oh = cand_oh;
            end
        end
        win_byte = 8'(bus.req_data >> (8 * int'(win)));
    end

    // Next state and registered-output values.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        data_d  = data_q;
        rdy_d   = 1'b0;
        gid_d   = gid_q;
`ifdef ARB_DEDUP_EN
        seen_d  = seen_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d = S_SEND;
                    last_d  = win;
                    gid_d   = win;
                    ack_d   = win_oh;
`ifdef ARB_DEDUP_EN
                    // A repeat of the shown byte is consumed silently.
                    if (!(seen_q && win_byte == data_q)) begin
                        rdy_d  = 1'b1;
                        data_d = win_byte;
                    end
                    seen_d = 1'b1;
`else
                    rdy_d   = 1'b1;
                    data_d  = win_byte;
`endif
                end
            end
            S_SEND: begin
                // No strobe in SEND means a suppressed repeat: skip the gap.
                if (rdy_q && GAP > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(GAP - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= GW'(N_SRC - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= 8'h00;
            rdy_q   <= 1'b0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_DEDUP_EN
    // Validity of the last-delivered byte for repeat detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
`endif

    assign bus.req_ack   = ack_q;
    assign bus.out_data  = data_q;
    assign bus.out_ready = rdy_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = busy_q;
endmodule
